// File: rtl/alu_multicycle.sv
// alu_multicycle: execution-stage ALU with single-cycle logic/arith ops and an
// iterative shift-add multiplier behind a start/busy/done handshake.
// Optional build macro ALU_MUL_EARLY_EXIT_EN: when defined, a multiply finishes
// as soon as the remaining multiplier bits are all zero instead of always
// running WIDTH iterations.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b101;

    // Counter value seen on the last of the WIDTH iteration edges.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_done;

    state_t           w_nextState;
    logic [WIDTH-1:0] w_nextMcand;
    logic [WIDTH-1:0] w_nextMplier;
    logic [WIDTH-1:0] w_nextAcc;
    logic [CNT_W-1:0] w_nextCnt;
    logic [WIDTH-1:0] w_nextResult;
    logic             w_nextZero;
    logic             w_nextDone;
    logic [WIDTH-1:0] w_aluOut;
    logic [WIDTH-1:0] w_accSum;

    // Single-cycle result for the non-multiply opcodes; unused codes fall back to ADD.
    always_comb begin
        w_aluOut = SrcA + SrcB;
        case (ALUControl)
            OP_AND:  w_aluOut = SrcA & SrcB;
            OP_OR:   w_aluOut = SrcA | SrcB;
            OP_SUB:  w_aluOut = SrcA - SrcB;
            OP_SLT:  w_aluOut = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: w_aluOut = SrcA + SrcB;
        endcase
    end

    assign w_accSum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Next-state and datapath update: accept work in IDLE, iterate shift-add in MUL.
    always_comb begin
        w_nextState  = r_state;
        w_nextMcand  = r_mcand;
        w_nextMplier = r_mplier;
        w_nextAcc    = r_acc;
        w_nextCnt    = r_cnt;
        w_nextResult = r_result;
        w_nextZero   = r_zero;
        w_nextDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (ALUControl == OP_MUL) begin
                        w_nextMcand  = SrcA;
                        w_nextMplier = SrcB;
                        w_nextAcc    = '0;
                        w_nextCnt    = '0;
                        w_nextState  = MUL;
                    end else begin
                        w_nextResult = w_aluOut;
                        w_nextZero   = (w_aluOut == '0);
                        w_nextDone   = 1'b1;
                    end
                end
            end
            MUL: begin
                w_nextAcc    = w_accSum;
                w_nextMcand  = r_mcand << 1;
                w_nextMplier = r_mplier >> 1;
                w_nextCnt    = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_nextResult = w_accSum;
                    w_nextZero   = (w_accSum == '0);
                    w_nextDone   = 1'b1;
                    w_nextState  = IDLE;
                end
`ifdef ALU_MUL_EARLY_EXIT_EN
                if (r_mplier == '0) begin
                    w_nextResult = r_acc;
                    w_nextZero   = (r_acc == '0);
                    w_nextDone   = 1'b1;
                    w_nextState  = IDLE;
                end
`endif
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_mcand  <= w_nextMcand;
            r_mplier <= w_nextMplier;
            r_acc    <= w_nextAcc;
            r_cnt    <= w_nextCnt;
            r_result <= w_nextResult;
            r_zero   <= w_nextZero;
            r_done   <= w_nextDone;
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign busy      = (r_state == MUL);
    assign done      = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle against an
// arithmetic reference model. Honors ALU_MUL_EARLY_EXIT_EN for expected latency.
module tb_alu_multicycle;

    localparam int W = 32;

`ifdef ALU_MUL_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    ALUControl = 3'b000;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic [W-1:0]  ALUResult;
    logic          Zero;
    logic          busy;
    logic          done;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  lastResult = '0;
    logic [2:0]    singleOps [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};

    alu_multicycle #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ALUControl(ALUControl),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .ALUResult(ALUResult),
        .Zero(Zero),
        .busy(busy),
        .done(done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] modelResult(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b100: return a - b;
            3'b110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b101: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[W-1:0];
            end
            default: return a + b;
        endcase
    endfunction

    function automatic int modelLatency(input logic [W-1:0] b);
        int msb;
        msb = -1;
        if (!EarlyExit) return W;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2 > W) ? W : msb + 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ALUControl = 3'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
    endtask

    task automatic runSingle(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp;
        exp = modelResult(op, a, b);
        applyStimulus(op, a, b);
        checkOutput({tag, " result"}, ALUResult, exp);
        checkOutput({tag, " zero"}, {31'd0, Zero}, {31'd0, (exp == '0)});
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        lastResult = exp;
    endtask

    task automatic runMul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int poke1, input int poke2);
        logic [W-1:0] exp;
        int lat;
        int seen;
        exp  = modelResult(3'b101, a, b);
        lat  = modelLatency(b);
        seen = 0;
        applyStimulus(3'b101, a, b);
        checkOutput({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " done@accept"}, {31'd0, done}, 32'd0);
        for (int cyc = 1; cyc <= W + 8 && seen == 0; cyc++) begin
            @(negedge clk);
            if (cyc <= lat && (cyc == poke1 || cyc == poke2)) begin
                start      = 1'b1;
                ALUControl = 3'b010;
                SrcA       = $urandom;
                SrcB       = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                seen = cyc;
            end else begin
                checkOutput({tag, " busy while running"}, {31'd0, busy}, 32'd1);
                checkOutput({tag, " result held"}, ALUResult, lastResult);
            end
        end
        checkOutput({tag, " latency"}, 32'(seen), 32'(lat));
        checkOutput({tag, " result"}, ALUResult, exp);
        checkOutput({tag, " zero"}, {31'd0, Zero}, {31'd0, (exp == '0)});
        checkOutput({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        lastResult = exp;
    endtask

    task automatic checkQuiet(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, " done low"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " busy low"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " result stable"}, ALUResult, lastResult);
    endtask

    // Directed sequence followed by randomized single-cycle ops and multiplies.
    initial begin
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;

        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset result", ALUResult, 32'd0);
        checkOutput("reset zero", {31'd0, Zero}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lastResult = '0;

        runSingle("add overflow", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        runSingle("sub equal", 3'b100, 32'd5, 32'd5);
        runSingle("slt signed", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
        runSingle("and", 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        runSingle("or", 3'b001, 32'h0000_F0F0, 32'h0000_0FF0);
        runSingle("op111 add", 3'b111, 32'd3, 32'd4);
        checkQuiet("after singles");

        runMul("mul 12345x10", 32'h0001_2345, 32'h0000_0010, 0, 0);
        checkQuiet("after mul1");
        runMul("mul ffffffff sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        checkQuiet("after mul2");

        runMul("mul 3x7 ignored starts", 32'd3, 32'd7, 5, 20);
        runSingle("add in done cycle", 3'b010, 32'd100, 32'd23);
        checkQuiet("after back-to-back");

        applyStimulus(3'b101, 32'h0000_1234, 32'h8000_0001);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midmul reset result", ALUResult, 32'd0);
        checkOutput("midmul reset zero", {31'd0, Zero}, 32'd1);
        checkOutput("midmul reset busy", {31'd0, busy}, 32'd0);
        checkOutput("midmul reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastResult = '0;
        repeat (3) checkQuiet("after abort");
        runMul("mul 6x7 after reset", 32'd6, 32'd7, 0, 0);
        checkQuiet("after mul 6x7");

        runMul("mul 9x0", 32'd9, 32'd0, 0, 0);
        checkQuiet("after 9x0");
        runMul("mul 9x4", 32'd9, 32'd4, 0, 0);
        checkQuiet("after 9x4");
        runMul("mul 1x80000000", 32'd1, 32'h8000_0000, 0, 0);
        checkQuiet("after 1x80000000");

        for (int i = 0; i < 20; i++) begin
            op = singleOps[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 0) b = a;
            runSingle("random single", op, a, b);
        end
        checkQuiet("after random singles");

        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            lat = modelLatency(b);
            runMul("random mul", a, b, $urandom_range(1, lat), $urandom_range(1, lat));
            checkQuiet("after random mul");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
